// File: rtl/common_pkg.sv
// Shared LCD definitions: reader FSM state encoding, default bus timing
// constants and a small sizing helper. The LCD writer imports the same package.
package common_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        E_HI1,
        GAP,
        E_HI2,
        DONE
    } lcd_rd_state_t;

    localparam int LCD_SETUP_CYCLES  = 2;
    localparam int LCD_E_HIGH_CYCLES = 5;
    localparam int LCD_E_GAP_CYCLES  = 2;
    localparam int LCD_MAX_POLLS     = 255;

    // Largest of three timing parameters, used to size the shared phase counter
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_reader.sv
// 4-bit LCD read engine: issues one byte read as two E strobes (high nibble,
// then low nibble) and presents the assembled byte with a one-cycle valid.
// Optional feature macro: LCD_READER_BUSY_WAIT_EN -- re-reads the busy
// flag/address register while bit 7 is set, up to MAX_POLLS reads, flagging
// o_rd_timeout when the limit is reached.
module lcd_reader
    import common_pkg::*;
#(
    parameter int SETUP_CYCLES  = LCD_SETUP_CYCLES,
    parameter int E_HIGH_CYCLES = LCD_E_HIGH_CYCLES,
    parameter int E_GAP_CYCLES  = LCD_E_GAP_CYCLES,
    parameter int MAX_POLLS     = LCD_MAX_POLLS
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rd_req,
    input  logic       i_RS,
    inout  wire  [3:0] io_LCD_data,
    output logic       o_E,
    output logic       o_RW,
    output logic       o_RS,
    output logic [7:0] o_rd_data,
    output logic       o_rd_valid,
    output logic       o_rd_timeout,
    output logic       o_is_ready
);

    localparam int MAX_PHASE = max3(SETUP_CYCLES, E_HIGH_CYCLES, E_GAP_CYCLES);
    localparam int CNT_W     = $clog2(MAX_PHASE + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] E_LAST     = CNT_W'(E_HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(E_GAP_CYCLES - 1);

    // Every phase must last at least one cycle for the counter compares to work
    if (SETUP_CYCLES < 1 || E_HIGH_CYCLES < 1 || E_GAP_CYCLES < 1 || MAX_POLLS < 1) begin : g_bad_params
        $error("lcd_reader: timing parameters and MAX_POLLS must all be >= 1");
    end

    // The reader only listens on the nibble bus
    assign io_LCD_data = 4'bzzzz;

    lcd_rd_state_t    state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             rs_reg, rs_next;
    logic             sample_hi, sample_lo;
    logic             final_read;   // the read now completing ends the request
    logic             retry;        // DONE loops back to SETUP for another poll

    assign sample_hi = (state_reg == E_HI1) && (cnt_reg == E_LAST);
    assign sample_lo = (state_reg == E_HI2) && (cnt_reg == E_LAST);
    assign rs_next   = ((state_reg == IDLE) && i_rd_req) ? i_RS : rs_reg;

    // Next-state decode; requests are only looked at in IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (i_rd_req)                state_next = SETUP;
            SETUP:   if (cnt_reg == SETUP_LAST)   state_next = E_HI1;
            E_HI1:   if (cnt_reg == E_LAST)       state_next = GAP;
            GAP:     if (cnt_reg == GAP_LAST)     state_next = E_HI2;
            E_HI2:   if (cnt_reg == E_LAST)       state_next = DONE;
            DONE:    state_next = retry ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register plus shared phase counter, cleared on every state change
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            rs_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            rs_reg    <= rs_next;
            if (state_next != state_reg || state_reg == IDLE)
                cnt_reg <= '0;
            else
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Registered bus controls and status, decoded from the state being entered
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_E        <= 1'b0;
            o_RW       <= 1'b0;
            o_RS       <= 1'b0;
            o_rd_valid <= 1'b0;
            o_is_ready <= 1'b1;
        end else begin
            o_E        <= (state_next == E_HI1) || (state_next == E_HI2);
            o_RW       <= (state_next != IDLE);
            o_RS       <= (state_next != IDLE) ? rs_next : 1'b0;
            o_rd_valid <= sample_lo && final_read;
            o_is_ready <= (state_next == IDLE);
        end
    end

    // Capture each nibble on the edge that ends its E-high window
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_rd_data <= 8'h00;
        else if (sample_hi)
            o_rd_data[7:4] <= io_LCD_data;
        else if (sample_lo)
            o_rd_data[3:0] <= io_LCD_data;
    end

`ifdef LCD_READER_BUSY_WAIT_EN
    localparam int POLL_W = $clog2(MAX_POLLS + 1);

    logic [POLL_W-1:0] poll_cnt_reg;
    logic              retry_reg;
    logic              busy_seen;

    // Bit 7 of a busy-flag read is already latched when the low nibble lands
    assign busy_seen  = !rs_reg && o_rd_data[7];
    assign final_read = !busy_seen || (int'(poll_cnt_reg) + 1 >= MAX_POLLS);
    assign retry      = retry_reg;

    // Count reads within one request and decide at each byte end whether to poll again
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            poll_cnt_reg <= '0;
            retry_reg    <= 1'b0;
            o_rd_timeout <= 1'b0;
        end else begin
            o_rd_timeout <= 1'b0;
            if (state_reg == IDLE) begin
                poll_cnt_reg <= '0;
                retry_reg    <= 1'b0;
            end else if (sample_lo) begin
                poll_cnt_reg <= poll_cnt_reg + 1'b1;
                retry_reg    <= !final_read;
                o_rd_timeout <= busy_seen && final_read;
            end
        end
    end
`else
    assign final_read   = 1'b1;
    assign retry        = 1'b0;
    assign o_rd_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_reader.sv
// Directed bench for lcd_reader with a behavioural LCD that drives one nibble
// per E strobe from a table. Build with LCD_READER_BUSY_WAIT_EN to exercise
// busy polling (MAX_POLLS = 4 in that build).
module tb_lcd_reader;
    import common_pkg::*;

`ifdef LCD_READER_BUSY_WAIT_EN
    localparam int TB_MAX_POLLS = 4;
`else
    localparam int TB_MAX_POLLS = LCD_MAX_POLLS;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rd_req = 1'b0;
    logic       rs_in = 1'b0;
    tri   [3:0] lcd_bus;
    logic [3:0] lcd_nib = 4'h0;
    logic       e_o, rw_o, rs_o, rd_valid, rd_timeout, is_ready;
    logic [7:0] rd_data;

    int n_checks = 0;
    int n_fail = 0;
    int valid_cnt = 0;
    int timeout_cnt = 0;
    int strobe_cnt = 0;
    int seq_idx = 0;
    int lat;
    logic to_seen;
    logic [3:0] nib_seq [16];

    assign lcd_bus = lcd_nib;

    always #5 clk = ~clk;

    lcd_reader #(
        .SETUP_CYCLES (2),
        .E_HIGH_CYCLES(5),
        .E_GAP_CYCLES (2),
        .MAX_POLLS    (TB_MAX_POLLS)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rd_req    (rd_req),
        .i_RS        (rs_in),
        .io_LCD_data (lcd_bus),
        .o_E         (e_o),
        .o_RW        (rw_o),
        .o_RS        (rs_o),
        .o_rd_data   (rd_data),
        .o_rd_valid  (rd_valid),
        .o_rd_timeout(rd_timeout),
        .o_is_ready  (is_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // LCD model: present the next table nibble while E is high, park low otherwise
    always @(posedge e_o) begin
        lcd_nib = nib_seq[seq_idx[3:0]];
        seq_idx++;
        strobe_cnt++;
    end
    always @(negedge e_o) lcd_nib = 4'h0;

    // Per-cycle protocol checks and pulse counting
    always @(negedge clk) begin
        if (rd_valid) valid_cnt++;
        if (rd_timeout) timeout_cnt++;
        chk("e_high_while_write", {31'd0, e_o && !rw_o}, 32'd0);
        chk("bus_not_driven", {28'd0, lcd_bus}, {28'd0, lcd_nib});
    end

    task automatic wait_valid(input int limit, output int latency, output logic to);
        latency = -1;
        to = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (rd_valid) begin
                latency = c;
                to = rd_timeout;
                break;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) nib_seq[i] = 4'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_e", {31'd0, e_o}, 32'd0);
        chk("rst_rw", {31'd0, rw_o}, 32'd0);
        chk("rst_rs", {31'd0, rs_o}, 32'd0);
        chk("rst_data", {24'd0, rd_data}, 32'h00);
        chk("rst_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_timeout", {31'd0, rd_timeout}, 32'd0);
        chk("rst_ready", {31'd0, is_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Transaction 1: data read, LCD returns A then 5
        nib_seq[0] = 4'hA;
        nib_seq[1] = 4'h5;
        rd_req = 1'b1;
        rs_in  = 1'b1;
        @(posedge clk);                 // acceptance edge k
        @(negedge clk);
        rd_req = 1'b0;
        rs_in  = 1'b0;
        chk("tx1_accept_ready", {31'd0, is_ready}, 32'd0);
        chk("tx1_accept_rw", {31'd0, rw_o}, 32'd1);
        chk("tx1_accept_rs", {31'd0, rs_o}, 32'd1);
        chk("tx1_accept_e", {31'd0, e_o}, 32'd0);
        // n counts edges after k; DONE (valid) is the state after edge k+14,
        // the 15th cycle of the transaction
        for (int n = 1; n <= 15; n++) begin
            rd_req = (n == 5) || (n == 15);  // ignored mid-read, then raised during DONE
            rs_in  = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tx1_e_n%0d", n), {31'd0, e_o},
                {31'd0, (n >= 2 && n <= 6) || (n >= 9 && n <= 13)});
            chk($sformatf("tx1_valid_n%0d", n), {31'd0, rd_valid}, {31'd0, n == 14});
            chk($sformatf("tx1_ready_n%0d", n), {31'd0, is_ready}, {31'd0, n == 15});
            chk($sformatf("tx1_rs_n%0d", n), {31'd0, rs_o}, {31'd0, n <= 14});
            chk($sformatf("tx1_rw_n%0d", n), {31'd0, rw_o}, {31'd0, n <= 14});
            if (n == 7 || n == 8) chk($sformatf("tx1_hi_nib_n%0d", n), {24'd0, rd_data}, 32'hA0);
            if (n >= 14) chk($sformatf("tx1_data_n%0d", n), {24'd0, rd_data}, 32'hA5);
        end
        chk("tx1_valid_count", valid_cnt, 1);
        chk("tx1_strobes", strobe_cnt, 2);

        // Transaction 2: request held from DONE is taken one cycle later; reset mid-strobe
        nib_seq[2] = 4'h3;
        nib_seq[3] = 4'hC;
        @(posedge clk);                 // acceptance edge k2 (req still high, RS=0)
        @(negedge clk);
        rd_req = 1'b0;
        chk("tx2_accept_ready", {31'd0, is_ready}, 32'd0);
        chk("tx2_accept_rs", {31'd0, rs_o}, 32'd0);
        chk("tx2_data_held", {24'd0, rd_data}, 32'hA5);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("tx2_e_before_rst", {31'd0, e_o}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("tx2_rst_e", {31'd0, e_o}, 32'd0);
        chk("tx2_rst_rw", {31'd0, rw_o}, 32'd0);
        chk("tx2_rst_data", {24'd0, rd_data}, 32'h00);
        chk("tx2_rst_ready", {31'd0, is_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("tx2_no_valid", valid_cnt, 1);
        chk("tx2_idle_ready", {31'd0, is_ready}, 32'd1);

`ifdef LCD_READER_BUSY_WAIT_EN
        // Transaction 3: busy three times (80), then 12 -> one valid after 4 reads
        seq_idx = 0;
        strobe_cnt = 0;
        nib_seq[0] = 4'h8; nib_seq[1] = 4'h0;
        nib_seq[2] = 4'h8; nib_seq[3] = 4'h0;
        nib_seq[4] = 4'h8; nib_seq[5] = 4'h0;
        nib_seq[6] = 4'h1; nib_seq[7] = 4'h2;
        rd_req = 1'b1;
        rs_in  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rd_req = 1'b0;
        wait_valid(200, lat, to_seen);
        chk("tx3_latency", lat, 14 + 3 * 15);
        chk("tx3_data", {24'd0, rd_data}, 32'h12);
        chk("tx3_timeout", {31'd0, to_seen}, 32'd0);
        chk("tx3_strobes", strobe_cnt, 8);
        chk("tx3_valid_count", valid_cnt, 2);
        @(negedge clk);

        // Transaction 4: always busy (8F) -> timeout with valid after the 4th read
        seq_idx = 0;
        strobe_cnt = 0;
        for (int i = 0; i < 8; i++) nib_seq[i] = (i % 2 == 0) ? 4'h8 : 4'hF;
        rd_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd_req = 1'b0;
        wait_valid(200, lat, to_seen);
        chk("tx4_latency", lat, 14 + 3 * 15);
        chk("tx4_data", {24'd0, rd_data}, 32'h8F);
        chk("tx4_timeout", {31'd0, to_seen}, 32'd1);
        chk("tx4_strobes", strobe_cnt, 8);
        repeat (3) @(negedge clk);
        chk("tx4_timeout_count", timeout_cnt, 1);
        chk("tx4_ready", {31'd0, is_ready}, 32'd1);
`else
        // Transaction 3: busy-flag read returning 8F is a single plain read
        seq_idx = 0;
        strobe_cnt = 0;
        nib_seq[0] = 4'h8;
        nib_seq[1] = 4'hF;
        rd_req = 1'b1;
        rs_in  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rd_req = 1'b0;
        wait_valid(40, lat, to_seen);
        chk("tx3_latency", lat, 14);
        chk("tx3_data", {24'd0, rd_data}, 32'h8F);
        chk("tx3_timeout", {31'd0, to_seen}, 32'd0);
        chk("tx3_strobes", strobe_cnt, 2);
        repeat (3) @(negedge clk);
        chk("tx3_valid_count", valid_cnt, 2);
        chk("tx3_timeout_count", timeout_cnt, 0);
        chk("tx3_ready", {31'd0, is_ready}, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
